program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-low; ports: CLK in 1 (rising-edge clock), Reset_n in 1 (sync active-low reset).
REQ-002 SHALL have ports Go in 1 (program launch request), Abort in 1 (stop running program), Prog_Sel in 2 (program index sampled with Go).
REQ-003 SHALL have ports Halt_Instr in 1 (decoded halt in current instruction), Branch_Req in 1 (decoded branch), Branch_Cond in 1 (1 = take only if Zero; 0 = unconditional), Zero in 1 (ALU zero flag).
REQ-004 SHALL have config ports Cfg_We in 1 (write start-address table), Cfg_Idx in 2 (table entry), Cfg_Addr in 8 (entry data), Cfg_Max_We in 1 (write cycle limit), Cfg_Max in 16 (cycle limit data).
REQ-005 SHALL have outputs Start out 1 (load PC), Start_Addr out 8 (PC load value), Branch out 1 (PC += offset), Busy out 1, Done out 1, Timeout out 1, Cycle_Count out 16.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, RUN, DONE; Start, Branch, Busy, Done are combinational decodes of state plus the inputs named below.
REQ-007 SHALL, in IDLE or DONE with Go=1 and Abort=0, latch Start_Addr <= Table[Prog_Sel], clear Timeout, and go to LOAD next cycle.
REQ-008 SHALL use the pre-write table value when Cfg_We targets the Prog_Sel entry in the same cycle Go is accepted.
REQ-009 SHALL assert Start=1 only in LOAD, for exactly one cycle; LOAD -> RUN unconditionally (unless Abort); Cycle_Count <= 0 in LOAD.
REQ-010 SHALL, in RUN, assert Branch = Branch_Req & (~Branch_Cond | Zero) & ~Halt_Instr & ~Abort; Branch=0 in all other states.
REQ-011 SHALL increment Cycle_Count by 1 per RUN cycle, saturating at 0xFFFF; hold it in IDLE, LOAD-exit, and DONE.
REQ-012 SHALL, in RUN with Halt_Instr=1, go to DONE next cycle with Timeout=0.
REQ-013 SHALL, in RUN with Halt_Instr=0 and Cycle_Count == Max_Cycles, go to DONE next cycle with Timeout=1.
REQ-014 SHALL, in LOAD or RUN with Abort=1, go to IDLE next cycle; Done and Timeout stay 0; Abort has priority over Halt_Instr, timeout, and Branch.
REQ-015 SHALL assert Busy=1 in LOAD and RUN, Done=1 in DONE only; DONE holds until Go is accepted (Abort in DONE is ignored).
REQ-016 SHALL ignore Go in LOAD and RUN.
REQ-017 SHALL write Table[Cfg_Idx] <= Cfg_Addr on Cfg_We and Max_Cycles <= Cfg_Max on Cfg_Max_We in any state; a running program is unaffected by table writes, and a Max_Cycles write takes effect on the next RUN comparison.
REQ-018 SHALL treat Start_Addr as an 8-bit unsigned register and Cycle_Count/Max_Cycles as 16-bit unsigned; a Max_Cycles of 0 times out on the first RUN cycle.

Reset
REQ-019 SHALL, on Reset_n=0 at a rising CLK edge, set state=IDLE, Start_Addr=0x00, Cycle_Count=0, Timeout=0, Max_Cycles=0xFFFF, Table={0x00,0x40,0x80,0xC0} for indices 0..3.
REQ-020 SHALL give reset priority over all other inputs, including mid-RUN and during config writes; outputs Start=Branch=Busy=Done=0 after reset.

Verification
REQ-021 Launch: reset, Go=1, Prog_Sel=2 -> LOAD next cycle with Start=1 and Start_Addr=0x80, then RUN with Busy=1.
REQ-022 Branch: in RUN, Branch_Req=1, Branch_Cond=1, Zero=0 -> Branch=0; Zero=1 -> Branch=1; Branch_Cond=0 -> Branch=1 regardless of Zero.
REQ-023 Halt vs. branch: Halt_Instr=1 and Branch_Req=1 in the same RUN cycle -> Branch=0, Done=1 next cycle, Timeout=0, Cycle_Count frozen.
REQ-024 Timeout: Cfg_Max=5, launch, no halt -> DONE after Cycle_Count reaches 5, with Timeout=1; halt arriving on that same cycle -> Timeout=0.
REQ-025 Abort/reset: Abort=1 mid-RUN -> IDLE, Done=0; Reset_n=0 mid-RUN -> all REQ-019 values next cycle; relaunch from DONE with Go works.
REQ-026 Config race: Cfg_We=1, Cfg_Idx=1, Cfg_Addr=0x22 in the same cycle as Go with Prog_Sel=1 -> Start_Addr=0x40; the next launch -> 0x22.

Source files
------------

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Brief    : Launches a program from a 4-entry start-address table, then
//            tracks branch/halt/abort/timeout while the program runs.
// Revision : 1.0  initial release
// ============================================================================
module program_sequencer (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Go,
    input  logic        Abort,
    input  logic [1:0]  Prog_Sel,
    input  logic        Halt_Instr,
    input  logic        Branch_Req,
    input  logic        Branch_Cond,
    input  logic        Zero,
    input  logic        Cfg_We,
    input  logic [1:0]  Cfg_Idx,
    input  logic [7:0]  Cfg_Addr,
    input  logic        Cfg_Max_We,
    input  logic [15:0] Cfg_Max,
    output logic        Start,
    output logic [7:0]  Start_Addr,
    output logic        Branch,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout,
    output logic [15:0] Cycle_Count
);

    localparam logic [31:0] c_TABLE_RST = {8'hC0, 8'h80, 8'h40, 8'h00};
    localparam logic [15:0] c_MAX_RST   = 16'hFFFF;
    localparam logic [15:0] c_COUNT_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_table [4];
    logic [15:0] r_max_cycles;
    logic [7:0]  r_start_addr;
    logic [15:0] r_cycle_count;
    logic        r_timeout;

    logic        w_go_accept;
    logic        w_halt_exit;
    logic        w_timeout_exit;
    logic        w_run_stay;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        Start          = 1'b0;
        Busy           = 1'b0;
        Done           = 1'b0;
        Branch         = 1'b0;
        w_go_accept    = 1'b0;
        w_halt_exit    = 1'b0;
        w_timeout_exit = 1'b0;
        w_run_stay     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Go && !Abort) begin
                    w_go_accept  = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                Start        = 1'b1;
                Busy         = 1'b1;
                w_next_state = Abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                Busy   = 1'b1;
                Branch = Branch_Req & (~Branch_Cond | Zero) & ~Halt_Instr & ~Abort;
                // Abort outranks halt, which outranks the cycle-limit check.
                if (Abort) begin
                    w_next_state = S_IDLE;
                end else if (Halt_Instr) begin
                    w_halt_exit  = 1'b1;
                    w_next_state = S_DONE;
                end else if (r_cycle_count == r_max_cycles) begin
                    w_timeout_exit = 1'b1;
                    w_next_state   = S_DONE;
                end else begin
                    w_run_stay = 1'b1;
                end
            end
            S_DONE: begin
                Done = 1'b1;
                if (Go && !Abort) begin
                    w_go_accept  = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The terminating RUN cycle does not count, so the count freezes at the
    // value that was compared when the program stopped.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_start_addr  <= 8'h00;
            r_cycle_count <= 16'h0000;
            r_timeout     <= 1'b0;
            r_max_cycles  <= c_MAX_RST;
            for (int i = 0; i < 4; i++) begin
                r_table[i] <= c_TABLE_RST[i*8 +: 8];
            end
        end else begin
            if (w_go_accept) begin
                r_start_addr <= r_table[Prog_Sel];
                r_timeout    <= 1'b0;
            end
            if (w_halt_exit) begin
                r_timeout <= 1'b0;
            end
            if (w_timeout_exit) begin
                r_timeout <= 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_cycle_count <= 16'h0000;
            end else if (w_run_stay && (r_cycle_count != c_COUNT_SAT)) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
            if (Cfg_Max_We) begin
                r_max_cycles <= Cfg_Max;
            end
            if (Cfg_We) begin
                r_table[Cfg_Idx] <= Cfg_Addr;
            end
        end
    end

    assign Start_Addr  = r_start_addr;
    assign Timeout     = r_timeout;
    assign Cycle_Count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Brief    : Self-checking bench for program_sequencer with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_program_sequencer;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Go = 1'b0;
    logic        Abort = 1'b0;
    logic [1:0]  Prog_Sel = 2'd0;
    logic        Halt_Instr = 1'b0;
    logic        Branch_Req = 1'b0;
    logic        Branch_Cond = 1'b0;
    logic        Zero = 1'b0;
    logic        Cfg_We = 1'b0;
    logic [1:0]  Cfg_Idx = 2'd0;
    logic [7:0]  Cfg_Addr = 8'h00;
    logic        Cfg_Max_We = 1'b0;
    logic [15:0] Cfg_Max = 16'h0000;
    logic        Start;
    logic [7:0]  Start_Addr;
    logic        Branch;
    logic        Busy;
    logic        Done;
    logic        Timeout;
    logic [15:0] Cycle_Count;

    program_sequencer dut (
        .CLK(CLK), .Reset_n(Reset_n), .Go(Go), .Abort(Abort), .Prog_Sel(Prog_Sel),
        .Halt_Instr(Halt_Instr), .Branch_Req(Branch_Req), .Branch_Cond(Branch_Cond),
        .Zero(Zero), .Cfg_We(Cfg_We), .Cfg_Idx(Cfg_Idx), .Cfg_Addr(Cfg_Addr),
        .Cfg_Max_We(Cfg_Max_We), .Cfg_Max(Cfg_Max), .Start(Start),
        .Start_Addr(Start_Addr), .Branch(Branch), .Busy(Busy), .Done(Done),
        .Timeout(Timeout), .Cycle_Count(Cycle_Count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_tbl [4];
    logic [15:0] m_max;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        Go = 1'b0; Abort = 1'b0; Prog_Sel = 2'd0; Halt_Instr = 1'b0;
        Branch_Req = 1'b0; Branch_Cond = 1'b0; Zero = 1'b0;
        Cfg_We = 1'b0; Cfg_Idx = 2'd0; Cfg_Addr = 8'h00;
        Cfg_Max_We = 1'b0; Cfg_Max = 16'h0000;
    endtask

    task automatic model_reset;
        m_tbl[0] = 8'h00; m_tbl[1] = 8'h40; m_tbl[2] = 8'h80; m_tbl[3] = 8'hC0;
        m_max = 16'hFFFF;
    endtask

    // Leaves the DUT in LOAD with Go released.
    task automatic launch(input logic [1:0] sel);
        Go = 1'b1; Prog_Sel = sel;
        step;
        Go = 1'b0;
    endtask

    task automatic halt_now;
        Halt_Instr = 1'b1;
        step;
        Halt_Instr = 1'b0;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Go = 1'b1; Cfg_We = 1'b1; Cfg_Addr = 8'hAA; Cfg_Max_We = 1'b1;
        step;
        step;
        clear_inputs;
        Reset_n = 1'b1;
        model_reset;
        #1;
        checks++; if (Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", Start); end
        checks++; if (Branch !== 1'b0) begin errors++; $display("FAIL reset_branch: got %b want 0", Branch); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", Timeout); end
        checks++; if (Start_Addr !== 8'h00) begin errors++; $display("FAIL reset_start_addr: got %h want 00", Start_Addr); end
        checks++; if (Cycle_Count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", Cycle_Count); end
    endtask

    task automatic test_launch;
        logic [1:0] sels [4];
        sels[0] = 2'd2; sels[1] = 2'd0; sels[2] = 2'd1; sels[3] = 2'd3;
        for (int k = 0; k < 4; k++) begin
            launch(sels[k]);
            checks++; if (Start !== 1'b1) begin errors++; $display("FAIL launch_start: got %b want 1", Start); end
            checks++; if (Start_Addr !== m_tbl[sels[k]]) begin errors++; $display("FAIL launch_addr sel=%0d: got %h want %h", sels[k], Start_Addr, m_tbl[sels[k]]); end
            checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL launch_busy_load: got %b want 1", Busy); end
            step;
            checks++; if (Start !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL launch_run: got start=%b busy=%b want start=0 busy=1", Start, Busy); end
            // Go must be ignored while running.
            Go = 1'b1; Prog_Sel = ~sels[k];
            step;
            Go = 1'b0;
            checks++; if (Start !== 1'b0 || Start_Addr !== m_tbl[sels[k]]) begin errors++; $display("FAIL go_in_run: got start=%b addr=%h want start=0 addr=%h", Start, Start_Addr, m_tbl[sels[k]]); end
            halt_now;
            checks++; if (Done !== 1'b1 || Timeout !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL launch_halt: got done=%b to=%b busy=%b want 1 0 0", Done, Timeout, Busy); end
            checks++; if (Cycle_Count !== 16'd1) begin errors++; $display("FAIL launch_count: got %0d want 1", Cycle_Count); end
        end
    endtask

    task automatic test_branch;
        logic [2:0] fixed [5];
        logic       req, cond, zero, exp_b;
        fixed[0] = 3'b110; fixed[1] = 3'b111; fixed[2] = 3'b100; fixed[3] = 3'b101; fixed[4] = 3'b001;
        launch(2'd0);
        step;
        for (int k = 0; k < 35; k++) begin
            if (k < 5) begin
                {req, cond, zero} = fixed[k];
            end else begin
                req = 1'($urandom_range(0, 1)); cond = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
            end
            Branch_Req = req; Branch_Cond = cond; Zero = zero;
            exp_b = req && (!cond || zero);
            #1;
            checks++; if (Branch !== exp_b) begin errors++; $display("FAIL branch req=%b cond=%b zero=%b: got %b want %b", req, cond, zero, Branch, exp_b); end
            step;
        end
        Abort = 1'b1; Branch_Req = 1'b1; Branch_Cond = 1'b0;
        #1;
        checks++; if (Branch !== 1'b0) begin errors++; $display("FAIL branch_abort: got %b want 0", Branch); end
        step;
        clear_inputs;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Timeout !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b done=%b to=%b want 0 0 0", Busy, Done, Timeout); end
        Go = 1'b1; Abort = 1'b1;
        step;
        clear_inputs;
        checks++; if (Busy !== 1'b0 || Start !== 1'b0) begin errors++; $display("FAIL go_with_abort: got busy=%b start=%b want 0 0", Busy, Start); end
    endtask

    task automatic test_halt_branch;
        launch(2'd3);
        step;
        step; step; step;
        Halt_Instr = 1'b1; Branch_Req = 1'b1; Branch_Cond = 1'b1; Zero = 1'b1;
        #1;
        checks++; if (Branch !== 1'b0) begin errors++; $display("FAIL halt_branch: got %b want 0", Branch); end
        step;
        clear_inputs;
        checks++; if (Done !== 1'b1 || Timeout !== 1'b0) begin errors++; $display("FAIL halt_done: got done=%b to=%b want 1 0", Done, Timeout); end
        checks++; if (Cycle_Count !== 16'd3) begin errors++; $display("FAIL halt_count: got %0d want 3", Cycle_Count); end
        Abort = 1'b1;
        step; step;
        Abort = 1'b0;
        checks++; if (Done !== 1'b1 || Cycle_Count !== 16'd3) begin errors++; $display("FAIL done_hold: got done=%b count=%0d want 1 3", Done, Cycle_Count); end
    endtask

    task automatic test_timeout;
        Cfg_Max_We = 1'b1; Cfg_Max = 16'd5;
        step;
        clear_inputs;
        m_max = 16'd5;
        // Runs out the cycle limit.
        launch(2'd1);
        step;
        for (int i = 0; i <= 5; i++) begin
            checks++; if (Busy !== 1'b1 || Cycle_Count !== 16'(i)) begin errors++; $display("FAIL to_run i=%0d: got busy=%b count=%0d want 1 %0d", i, Busy, Cycle_Count, i); end
            step;
        end
        checks++; if (Done !== 1'b1 || Timeout !== 1'b1 || Cycle_Count !== 16'd5) begin errors++; $display("FAIL to_done: got done=%b to=%b count=%0d want 1 1 5", Done, Timeout, Cycle_Count); end
        // Halt on the very cycle the limit is reached wins.
        launch(2'd1);
        step;
        for (int i = 0; i < 5; i++) step;
        halt_now;
        checks++; if (Done !== 1'b1 || Timeout !== 1'b0 || Cycle_Count !== 16'd5) begin errors++; $display("FAIL to_halt: got done=%b to=%b count=%0d want 1 0 5", Done, Timeout, Cycle_Count); end
        // A zero limit expires on the first RUN cycle.
        Cfg_Max_We = 1'b1; Cfg_Max = 16'd0;
        step;
        clear_inputs;
        launch(2'd2);
        step;
        step;
        checks++; if (Done !== 1'b1 || Timeout !== 1'b1 || Cycle_Count !== 16'd0) begin errors++; $display("FAIL to_zero: got done=%b to=%b count=%0d want 1 1 0", Done, Timeout, Cycle_Count); end
        // A limit written mid-run applies to the following comparison.
        Cfg_Max_We = 1'b1; Cfg_Max = 16'd100;
        step;
        clear_inputs;
        launch(2'd0);
        step;
        step; step; step;
        Cfg_Max_We = 1'b1; Cfg_Max = 16'd4;
        step;
        clear_inputs;
        checks++; if (Done !== 1'b0 || Cycle_Count !== 16'd4) begin errors++; $display("FAIL max_write_run: got done=%b count=%0d want 0 4", Done, Cycle_Count); end
        step;
        checks++; if (Done !== 1'b1 || Timeout !== 1'b1 || Cycle_Count !== 16'd4) begin errors++; $display("FAIL max_write_done: got done=%b to=%b count=%0d want 1 1 4", Done, Timeout, Cycle_Count); end
        Reset_n = 1'b0;
        step;
        Reset_n = 1'b1;
        model_reset;
        checks++; if (Timeout !== 1'b0 || Done !== 1'b0 || Cycle_Count !== 16'd0) begin errors++; $display("FAIL reset_after_to: got to=%b done=%b count=%0d want 0 0 0", Timeout, Done, Cycle_Count); end
    endtask

    task automatic test_reset_midrun;
        launch(2'd2);
        step;
        step; step; step;
        Reset_n = 1'b0; Go = 1'b1; Cfg_We = 1'b1; Cfg_Idx = 2'd1; Cfg_Addr = 8'h55;
        Cfg_Max_We = 1'b1; Cfg_Max = 16'd2;
        step;
        clear_inputs;
        Reset_n = 1'b1;
        model_reset;
        checks++; if (Busy !== 1'b0 || Start !== 1'b0 || Done !== 1'b0 || Branch !== 1'b0) begin errors++; $display("FAIL midrun_reset_outs: got busy=%b start=%b done=%b br=%b want all 0", Busy, Start, Done, Branch); end
        checks++; if (Start_Addr !== 8'h00 || Cycle_Count !== 16'd0 || Timeout !== 1'b0) begin errors++; $display("FAIL midrun_reset_regs: got addr=%h count=%0d to=%b want 00 0 0", Start_Addr, Cycle_Count, Timeout); end
        launch(2'd1);
        checks++; if (Start_Addr !== 8'h40) begin errors++; $display("FAIL midrun_reset_table: got %h want 40", Start_Addr); end
        step;
        for (int i = 0; i < 10; i++) step;
        checks++; if (Done !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL midrun_reset_max: got done=%b busy=%b want 0 1", Done, Busy); end
        halt_now;
    endtask

    task automatic test_config_race;
        Cfg_We = 1'b1; Cfg_Idx = 2'd1; Cfg_Addr = 8'h22; Go = 1'b1; Prog_Sel = 2'd1;
        step;
        clear_inputs;
        checks++; if (Start_Addr !== m_tbl[1]) begin errors++; $display("FAIL race_prewrite: got %h want %h", Start_Addr, m_tbl[1]); end
        m_tbl[1] = 8'h22;
        step;
        Cfg_We = 1'b1; Cfg_Idx = 2'd2; Cfg_Addr = 8'h99;
        step;
        clear_inputs;
        m_tbl[2] = 8'h99;
        checks++; if (Start_Addr !== 8'h40 || Busy !== 1'b1) begin errors++; $display("FAIL race_running: got addr=%h busy=%b want 40 1", Start_Addr, Busy); end
        halt_now;
        launch(2'd1);
        checks++; if (Start_Addr !== m_tbl[1]) begin errors++; $display("FAIL race_next: got %h want %h", Start_Addr, m_tbl[1]); end
        step;
        halt_now;
        launch(2'd2);
        checks++; if (Start_Addr !== m_tbl[2]) begin errors++; $display("FAIL race_idx2: got %h want %h", Start_Addr, m_tbl[2]); end
        step;
        halt_now;
    endtask

    task automatic test_random_programs;
        logic [1:0]  sel;
        int unsigned h, a;
        logic        req, cond, zero, exp_b, ended, aborted, timed;
        int          last;
        logic        wr;
        logic [1:0]  widx;
        logic [7:0]  waddr;
        for (int n = 0; n < 25; n++) begin
            Cfg_Max_We = 1'b1; Cfg_Max = 16'($urandom_range(0, 12));
            Cfg_We = 1'b1; Cfg_Idx = 2'($urandom_range(0, 3)); Cfg_Addr = 8'($urandom_range(0, 255));
            step;
            m_max = Cfg_Max;
            m_tbl[Cfg_Idx] = Cfg_Addr;
            clear_inputs;
            sel = 2'($urandom_range(0, 3));
            h = $urandom_range(0, 15);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 99;
            launch(sel);
            checks++; if (Start_Addr !== m_tbl[sel]) begin errors++; $display("FAIL rnd_addr n=%0d: got %h want %h", n, Start_Addr, m_tbl[sel]); end
            step;
            ended = 1'b0; aborted = 1'b0; timed = 1'b0; last = 0;
            for (int i = 0; i < 40 && !ended; i++) begin
                req = 1'($urandom_range(0, 1)); cond = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
                wr = ($urandom_range(0, 3) == 0); widx = 2'($urandom_range(0, 3)); waddr = 8'($urandom_range(0, 255));
                Branch_Req = req; Branch_Cond = cond; Zero = zero;
                Halt_Instr = (i == h); Abort = (i == a);
                Cfg_We = wr; Cfg_Idx = widx; Cfg_Addr = waddr;
                exp_b = (i == a || i == h) ? 1'b0 : (req && (!cond || zero));
                #1;
                checks++; if (Branch !== exp_b || Cycle_Count !== 16'(i)) begin errors++; $display("FAIL rnd_run n=%0d i=%0d: got br=%b count=%0d want %b %0d", n, i, Branch, Cycle_Count, exp_b, i); end
                if (i == a) begin ended = 1'b1; aborted = 1'b1; end
                else if (i == h) begin ended = 1'b1; end
                else if (16'(i) == m_max) begin ended = 1'b1; timed = 1'b1; end
                last = i;
                step;
                if (wr) m_tbl[widx] = waddr;
            end
            clear_inputs;
            if (!ended) begin
                errors++; $display("FAIL rnd_bound n=%0d: got no termination want end within 40 cycles", n);
            end
            checks++; if (Busy !== 1'b0 || Done !== !aborted || Timeout !== timed) begin errors++; $display("FAIL rnd_end n=%0d: got busy=%b done=%b to=%b want 0 %b %b", n, Busy, Done, Timeout, !aborted, timed); end
            if (!aborted) begin
                checks++; if (Cycle_Count !== 16'(last)) begin errors++; $display("FAIL rnd_count n=%0d: got %0d want %0d", n, Cycle_Count, last); end
            end
        end
    endtask

    initial begin
        clear_inputs;
        model_reset;
        test_reset;
        test_launch;
        test_branch;
        test_halt_branch;
        test_timeout;
        test_reset_midrun;
        test_config_race;
        test_random_programs;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
